// File: rtl/ysyx_24110015_lsu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_lsu_pkg
// Shared definitions for the load/store unit: FSM state encoding, func3 codes
// for the supported access sizes, base byte-strobe patterns and small decode
// helpers used by the top level.
// ----------------------------------------------------------------------------
package ysyx_24110015_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Strobe pattern for an access starting at byte lane 0.
  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  function automatic logic store_f3_legal(input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return ok;
  endfunction

  // func3[1:0] carries the access size for every legal encoding, so the
  // alignment check only needs those two bits.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = (off == 2'd3);
      2'b10:   bad = (off != 2'd0);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] base_strb(input logic [2:0] f3);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = STRB_B;
      2'b01:   s = STRB_H;
      default: s = STRB_W;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ysyx_24110015_lsu_ldext.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_lsu_ldext
// Combinational load extractor: shifts the addressed bytes of a bus word down
// to bit 0 and sign/zero extends them according to func3.
//   rdata_i   : 32-bit word returned by the bus
//   off_i     : byte offset of the access within the word
//   func3_i   : load size/sign code
//   data_o    : extended writeback value
//   illegal_o : func3 is not a supported load encoding
// ----------------------------------------------------------------------------
module ysyx_24110015_lsu_ldext
  import ysyx_24110015_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o,
  output logic        illegal_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    data_o    = '0;
    illegal_o = 1'b0;
    case (func3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    data_o = shifted;
      F3_BU:   data_o = {24'd0, shifted[7:0]};
      F3_HU:   data_o = {16'd0, shifted[15:0]};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_24110015_lsu.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_lsu
// Load/store unit between EXU and WBU. Accepts one instruction per handshake,
// performs at most one aligned word-bus transaction, and presents the
// writeback result to WBU with a valid/ready handshake.
//   clk, rst          : clock, asynchronous active-low reset
//   in_*              : instruction from EXU (valid/ready handshake)
//   out_*             : writeback result to WBU (valid/ready handshake)
//   mem_req_*         : data-memory request (valid/ready)
//   mem_rsp_*         : data-memory response (always accepted in WAIT)
// ----------------------------------------------------------------------------
module ysyx_24110015_lsu
  import ysyx_24110015_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [2:0]        in_func3,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_reg_write,
  input  logic [4:0]        in_wb_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_wb_data,
  output logic              out_reg_write,
  output logic [4:0]        out_wb_addr,
  output logic              out_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata,
  input  logic              mem_rsp_err
);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        func3_q;
  logic              load_q;
  logic              store_q;
  logic              rw_q;
  logic [4:0]        wb_addr_q;
  logic [31:0]       wb_data_q;
  logic              err_q;

  logic              err_d;
  logic [2:0]        ext_func3;
  logic [1:0]        ext_off;
  logic [31:0]       ext_data;
  logic              ext_illegal;
  logic              req_active;
  logic [1:0]        off_q;

  assign off_q = addr_q[1:0];

  // One extractor serves both jobs: in IDLE it judges the incoming func3 for
  // load legality, afterwards it extends the response of the captured access.
  assign ext_func3 = (state_q == S_IDLE) ? in_func3 : func3_q;
  assign ext_off   = (state_q == S_IDLE) ? in_addr[1:0] : off_q;

  ysyx_24110015_lsu_ldext u_ldext (
    .rdata_i   (mem_rsp_rdata),
    .off_i     (ext_off),
    .func3_i   (ext_func3),
    .data_o    (ext_data),
    .illegal_o (ext_illegal)
  );

  always_comb begin
    err_d = 1'b0;
    if (in_mem_read && in_mem_write) begin
      err_d = 1'b1;
    end else if (in_mem_read) begin
      err_d = ext_illegal || misaligned(in_func3, in_addr[1:0]);
    end else if (in_mem_write) begin
      err_d = !store_f3_legal(in_func3) || misaligned(in_func3, in_addr[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      func3_q   <= '0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      rw_q      <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            addr_q    <= in_addr;
            wdata_q   <= in_wdata;
            func3_q   <= in_func3;
            load_q    <= in_mem_read;
            store_q   <= in_mem_write;
            rw_q      <= in_reg_write;
            wb_addr_q <= in_wb_addr;
            err_q     <= err_d;
            if (err_d) begin
              wb_data_q <= '0;
              state_q   <= S_DONE;
            end else if (in_mem_read || in_mem_write) begin
              wb_data_q <= '0;
              state_q   <= S_REQ;
            end else begin
              wb_data_q <= 32'(in_addr);
              state_q   <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            state_q <= S_DONE;
            if (mem_rsp_err) begin
              err_q     <= 1'b1;
              wb_data_q <= '0;
            end else if (load_q) begin
              wb_data_q <= ext_data;
            end else begin
              wb_data_q <= '0;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // in_ready must read 0 while reset is held even though the state is IDLE.
  assign in_ready      = rst && (state_q == S_IDLE);

  assign out_valid     = (state_q == S_DONE);
  assign out_wb_data   = wb_data_q;
  assign out_wb_addr   = wb_addr_q;
  assign out_err       = err_q;
  assign out_reg_write = rw_q && !err_q && !store_q;

  assign req_active    = (state_q == S_REQ);
  assign mem_req_valid = req_active;
  assign mem_req_we    = req_active && store_q;
  assign mem_req_addr  = req_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_req_wdata = req_active ? (wdata_q << {off_q, 3'b000}) : '0;
  assign mem_req_wstrb = (req_active && store_q) ? (base_strb(func3_q) << off_q) : 4'b0000;

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
`timescale 1ns/1ps
module tb_ysyx_24110015_lsu;

  localparam int ADDR_W  = 32;
  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_DONE = 3;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid, in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_wdata;
  logic [2:0]        in_func3;
  logic              in_mem_read, in_mem_write, in_reg_write;
  logic [4:0]        in_wb_addr;
  logic              out_valid, out_ready;
  logic [31:0]       out_wb_data;
  logic              out_reg_write, out_err;
  logic [4:0]        out_wb_addr;
  logic              mem_req_valid, mem_req_ready, mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_wdata;
  logic [3:0]        mem_req_wstrb;
  logic              mem_rsp_valid, mem_rsp_err;
  logic [31:0]       mem_rsp_rdata;

  always #5 clk = ~clk;

  ysyx_24110015_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_func3(in_func3), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write), .in_wb_addr(in_wb_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_wb_data(out_wb_data),
    .out_reg_write(out_reg_write), .out_wb_addr(out_wb_addr), .out_err(out_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        rd;
    logic        wr;
    logic        rw;
    logic [4:0]  wba;
    logic [31:0] rdata;
    logic        rerr;
  } txn_t;

  typedef struct packed {
    logic        req;
    logic [31:0] raddr;
    logic [31:0] rwdata;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wb;
    logic        rw;
    logic        err;
    logic [4:0]  wba;
  } exp_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   phase  = PH_IDLE;
  bit   cmp_en = 1'b0;
  exp_t ex;

  logic [31:0] got_raddr, got_wdata, got_wb;
  logic [3:0]  got_strb;
  logic        got_we, got_rw, got_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
  endtask

  // Reference: the outcome of one instruction derived directly from the
  // access rules (size in bytes, byte offset, legal code lists).
  function automatic exp_t model(input txn_t t);
    exp_t        e;
    int          off, n;
    logic [31:0] mask, raw;
    bit          legal;
    e     = '0;
    e.wba = t.wba;
    off   = int'(t.addr[1:0]);
    n     = 1 << int'(t.f3[1:0]);
    if (!t.rd && !t.wr) begin
      e.wb = t.addr;
      e.rw = t.rw;
      return e;
    end
    legal = t.rd ? (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (t.f3 inside {3'd0, 3'd1, 3'd2});
    if ((t.rd && t.wr) || !legal || (off + n > 4)) begin
      e.err = 1'b1;
      return e;
    end
    e.req   = 1'b1;
    e.raddr = t.addr - 32'(off);
    e.we    = t.wr;
    if (t.wr) begin
      e.strb   = 4'(((1 << n) - 1) << off);
      e.rwdata = t.wdata << (8 * off);
    end
    if (t.rerr) begin
      e.err = 1'b1;
      return e;
    end
    if (t.wr) return e;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    raw  = (t.rdata >> (8 * off)) & mask;
    if (t.f3 < 3'd4 && n < 4 && raw[8 * n - 1]) raw = raw | ~mask;
    e.wb = raw;
    e.rw = t.rw;
    return e;
  endfunction

  function automatic txn_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                              input logic rd, input logic wr, input logic rw, input logic [4:0] wba,
                              input logic [31:0] rdata, input logic rerr);
    txn_t t;
    t.addr = a; t.wdata = wd; t.f3 = f3; t.rd = rd; t.wr = wr; t.rw = rw;
    t.wba = wba; t.rdata = rdata; t.rerr = rerr;
    return t;
  endfunction

  // Per-cycle compare against the phase the bench has placed the transaction in.
  always @(negedge clk) begin
    if (rst === 1'b1 && cmp_en) begin
      check("in_ready", 32'(in_ready), 32'(phase == PH_IDLE));
      check("mem_req_valid", 32'(mem_req_valid), 32'(phase == PH_REQ));
      check("out_valid", 32'(out_valid), 32'(phase == PH_DONE));
      if (phase == PH_IDLE) begin
        got_raddr <= SENT; got_wdata <= SENT; got_wb <= SENT;
        got_strb <= 4'hA; got_we <= 1'bx; got_rw <= 1'bx; got_err <= 1'bx;
      end
      if (phase == PH_REQ) begin
        check("req_addr", mem_req_addr, ex.raddr);
        check("req_we", 32'(mem_req_we), 32'(ex.we));
        check("req_wstrb", 32'(mem_req_wstrb), 32'(ex.strb));
        if (ex.we) check("req_wdata", mem_req_wdata, ex.rwdata);
        got_raddr <= mem_req_addr; got_wdata <= mem_req_wdata;
        got_strb <= mem_req_wstrb; got_we <= mem_req_we;
      end
      if (phase == PH_DONE) begin
        check("out_err", 32'(out_err), 32'(ex.err));
        check("out_reg_write", 32'(out_reg_write), 32'(ex.rw));
        check("out_wb_addr", 32'(out_wb_addr), 32'(ex.wba));
        if (!ex.err) check("out_wb_data", out_wb_data, ex.wb);
        got_wb <= out_wb_data; got_rw <= out_reg_write; got_err <= out_err;
      end
    end
  end

  task automatic offer(input txn_t t);
    in_valid = 1'b1; in_addr = t.addr; in_wdata = t.wdata; in_func3 = t.f3;
    in_mem_read = t.rd; in_mem_write = t.wr; in_reg_write = t.rw; in_wb_addr = t.wba;
  endtask

  task automatic scramble_in();
    in_valid = 1'($urandom); in_addr = $urandom; in_wdata = $urandom; in_func3 = 3'($urandom);
    in_mem_read = 1'($urandom); in_mem_write = 1'($urandom); in_reg_write = 1'($urandom);
    in_wb_addr = 5'($urandom);
  endtask

  // Entered and left at posedge+1 with the LSU expected idle.
  task automatic run_txn(input txn_t t, input int dreq, input int drsp, input int dout);
    ex = model(t);
    offer(t);
    @(posedge clk); #1;
    scramble_in();
    if (ex.req) begin
      phase = PH_REQ;
      for (int i = 0; i < dreq; i++) begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'($urandom); mem_rsp_rdata = $urandom; mem_rsp_err = 1'($urandom);
        @(posedge clk); #1;
        scramble_in();
      end
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'($urandom); mem_rsp_rdata = $urandom; mem_rsp_err = 1'($urandom);
      @(posedge clk); #1;
      phase = PH_WAIT;
      mem_req_ready = 1'($urandom);
      for (int i = 0; i < drsp; i++) begin
        mem_rsp_valid = 1'b0; mem_rsp_rdata = $urandom; mem_rsp_err = 1'($urandom);
        @(posedge clk); #1;
      end
      mem_rsp_valid = 1'b1; mem_rsp_rdata = t.rdata; mem_rsp_err = t.rerr;
      @(posedge clk); #1;
    end
    phase = PH_DONE;
    for (int i = 0; i < dout; i++) begin
      out_ready = 1'b0;
      mem_rsp_valid = 1'($urandom); mem_rsp_rdata = $urandom; mem_rsp_err = 1'($urandom);
      @(posedge clk); #1;
      scramble_in();
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    phase = PH_IDLE;
  endtask

  initial begin
    txn_t t;
    int   kind, idx, dq, ds, dd;

    in_valid = 0; in_addr = 0; in_wdata = 0; in_func3 = 0; in_mem_read = 0; in_mem_write = 0;
    in_reg_write = 0; in_wb_addr = 0; out_ready = 0; mem_req_ready = 0;
    mem_rsp_valid = 0; mem_rsp_rdata = 0; mem_rsp_err = 0;

    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_wb_data", out_wb_data, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_reg_write", 32'(out_reg_write), 32'd0);
    check("rst_req_wstrb", 32'(mem_req_wstrb), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // Directed cases with hand-computed results.
    run_txn(mk(32'h0000_1234, 32'h0, 3'b000, 0, 0, 1, 5'd5, 32'h0, 0), 0, 0, 0);
    check("nonmem_wb", got_wb, 32'h0000_1234);
    check("nonmem_rw", 32'(got_rw), 32'd1);
    check("nonmem_err", 32'(got_err), 32'd0);

    run_txn(mk(32'h8000_0003, 32'h0, 3'b000, 1, 0, 1, 5'd7, 32'h80AA_BBCC, 0), 0, 0, 0);
    check("lb_req_addr", got_raddr, 32'h8000_0000);
    check("lb_wstrb", 32'(got_strb), 32'd0);
    check("lb_we", 32'(got_we), 32'd0);
    check("lb_wb", got_wb, 32'hFFFF_FF80);

    run_txn(mk(32'h8000_0003, 32'h0, 3'b100, 1, 0, 1, 5'd7, 32'h80AA_BBCC, 0), 0, 0, 0);
    check("lbu_wb", got_wb, 32'h0000_0080);

    run_txn(mk(32'h8000_0002, 32'h0000_BEEF, 3'b001, 0, 1, 1, 5'd9, 32'h0, 0), 0, 0, 0);
    check("sh_we", 32'(got_we), 32'd1);
    check("sh_wstrb", 32'(got_strb), 32'b1100);
    check("sh_wdata", got_wdata, 32'hBEEF_0000);
    check("sh_rw", 32'(got_rw), 32'd0);

    run_txn(mk(32'h8000_0010, 32'h0, 3'b010, 1, 0, 1, 5'd3, 32'h1234_5678, 0), 3, 2, 2);
    check("bp_lw_wb", got_wb, 32'h1234_5678);

    run_txn(mk(32'h8000_0001, 32'h0, 3'b010, 1, 0, 1, 5'd4, 32'h0, 0), 0, 0, 0);
    check("lw_mis_err", 32'(got_err), 32'd1);
    check("lw_mis_rw", 32'(got_rw), 32'd0);
    check("lw_mis_noreq", got_raddr, SENT);

    run_txn(mk(32'h8000_0000, 32'h0, 3'b011, 1, 0, 1, 5'd4, 32'h0, 0), 0, 0, 0);
    check("f3_011_err", 32'(got_err), 32'd1);

    run_txn(mk(32'h8000_0008, 32'h0, 3'b010, 1, 0, 1, 5'd6, 32'hCAFE_F00D, 1), 1, 1, 0);
    check("rsp_err_err", 32'(got_err), 32'd1);
    check("rsp_err_rw", 32'(got_rw), 32'd0);

    // Reset while waiting for the response.
    t  = mk(32'h8000_0020, 32'h0, 3'b010, 1, 0, 1, 5'd2, 32'h0, 0);
    ex = model(t);
    offer(t);
    @(posedge clk); #1;
    in_valid = 1'b0;
    phase = PH_REQ; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0; phase = PH_WAIT;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    check("rstmid_req_valid", 32'(mem_req_valid), 32'd0);
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd0);
    phase = PH_IDLE;
    @(posedge clk);
    #2 rst = 1'b1;
    run_txn(mk(32'h8000_0024, 32'h0, 3'b010, 1, 0, 1, 5'd11, 32'hA5A5_0F0F, 0), 0, 0, 0);
    check("post_rst_lw_wb", got_wb, 32'hA5A5_0F0F);
    check("post_rst_lw_rw", 32'(got_rw), 32'd1);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      kind   = $urandom_range(0, 9);
      t      = '0;
      t.addr = $urandom; t.wdata = $urandom; t.rdata = $urandom;
      t.wba  = 5'($urandom); t.rw = 1'($urandom);
      t.rerr = ($urandom_range(0, 9) == 0);
      t.rd   = (kind >= 2 && kind <= 5) || kind == 9;
      t.wr   = (kind >= 6);
      if ($urandom_range(0, 6) == 0) begin
        t.f3 = 3'($urandom);
      end else if (t.wr && !t.rd) begin
        t.f3 = 3'($urandom_range(0, 2));
      end else begin
        idx  = $urandom_range(0, 4);
        t.f3 = (idx < 3) ? 3'(idx) : 3'(idx + 1);
      end
      if ($urandom_range(0, 3) != 0) begin
        if (t.f3[1:0] == 2'b10) t.addr[1:0] = 2'b00;
        else if (t.f3[1:0] == 2'b01 && t.addr[1:0] == 2'b11) t.addr[1:0] = 2'b10;
      end
      if ($urandom_range(0, 2) == 0) begin
        dq = 0; ds = 0; dd = 0;
      end else begin
        dq = $urandom_range(0, 3); ds = $urandom_range(0, 3); dd = $urandom_range(0, 3);
      end
      run_txn(t, dq, ds, dd);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
